ifetch_buffer: RTL and testbench
================================

# ifetch_buffer

Instruction-fetch front end for the single-cycle MIPS core: owns the fetch PC, requests words from a variable-latency instruction memory, and buffers fetched words with their PCs in a small prefetch queue. It sits directly upstream of the core datapath and supplies `instr` and `instr_pc` under a valid/ready handshake. The datapath stalls while `instr_valid` is low and redirects fetch on a taken branch or jump.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0

- `clk`  in  1  sole clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserting clears all state immediately
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  word-aligned fetch address; stable while `imem_req` is high and `imem_ack` is low
- `imem_ack`  in  1  memory accepts the request and returns `imem_rdata` in the same cycle
- `imem_rdata`  in  32  instruction word, valid only when `imem_ack` is high
- `redirect`  in  1  one-cycle pulse: flush the queue and restart at `redirect_pc`
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored and forced to 0
- `instr_valid`  out  1  queue head valid
- `instr`  out  32  queue head instruction word
- `instr_pc`  out  32  PC of the queue head
- `instr_ready`  in  1  datapath consumes the head when `instr_valid` and `instr_ready` are both high

## Operation
- Registers: `fpc` (next fetch PC), queue storage, `count` ($clog2(DEPTH+1) bits), FSM state.
- FSM states:
  - IDLE: no request outstanding. Goes to REQ when `count` < DEPTH.
  - REQ: `imem_req`=1, `imem_addr`=`fpc`.
  - DROP: request outstanding but already flushed. `imem_req` stays 1 and the address is held.
- Transitions:
  - REQ, ack without redirect: push {`fpc`, `imem_rdata`}, `fpc` += 4.
    - Stay in REQ if (`count`+push−pop) < DEPTH, otherwise go to IDLE.
  - REQ, redirect without ack: go to DROP, then `fpc` ← `redirect_pc`.
  - REQ, redirect and ack in the same cycle: discard the data, `fpc` ← `redirect_pc`, stay in REQ.
  - DROP, ack: discard the data, go to REQ at the new `fpc`.
  - DROP, further redirect: stay in DROP and update `fpc`; the latest redirect wins.
  - IDLE, redirect: `fpc` ← `redirect_pc`, go to REQ.
- Flush on `redirect`: `count` ← 0. The head and any same-cycle push are discarded, and a same-cycle pop is a no-op.
- Pop on full queue: the freed slot is not used in the same cycle. The next request issues the following cycle.
- `fpc` wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- At most one request is outstanding. `imem_req` never drops while a request is unacknowledged.
- Outputs on empty queue: `instr` and `instr_pc` hold the last head value. They are don't-care while `instr_valid`=0.

## Timing
- Reset values:
  - `imem_req`=0
  - `imem_addr`=`RESET_PC`
  - `instr_valid`=0
  - `instr`=0
  - `instr_pc`=0
  - `fpc`=`RESET_PC`
  - `count`=0
  - state IDLE
- First request: `imem_req` rises on the first rising edge after `reset` deasserts.
- Ack to head: an ack in cycle N gives `instr_valid`=1 in cycle N+1 when the queue was empty.
- Throughput: with a zero-wait memory (ack always 1) and `instr_ready`=1, one instruction per cycle and sequential PCs.
- Redirect to new data: redirect in cycle N gives `imem_addr`=`redirect_pc` in cycle N+1 (REQ or IDLE case). `instr_valid`=0 from cycle N+1 until that fetch returns.
- Reset mid-request: all state clears immediately. The pending ack is not waited for.

## Structure
- Package `ifetch_pkg`:
  - `ifetch_state_t` enum {IDLE, REQ, DROP}
  - `WORD_BYTES`=4
  - default `RESET_PC`
- Sub-module `ifq_fifo`: synchronous circular FIFO, parameterized by width and `DEPTH`, with push, pop, flush, count, head.
  - Pointers wrap modulo DEPTH.
  - The entry is {pc, instr}, 64 bits.
- Top: FSM, `fpc`, and request logic.

## Test plan
- Reset and stream: `RESET_PC`=0, ack always 1, ready always 1.
  - `imem_addr` sequence 0, 4, 8, …
  - `instr_pc` = 0, 4, 8, … starting one cycle after the first ack.
  - `instr` equals the memory word at each address.
- Full queue: ready=0, ack=1, DEPTH=4.
  - Exactly 4 pushes, then `imem_req`=0 and `count`=4.
  - One pop, then one more request at PC 16 on the next cycle.
- Slow memory: ack 3 cycles after each req.
  - `imem_addr` stable for 3 cycles per request.
  - PCs strictly sequential and no lost word.
- Redirect with request outstanding:
  - Redirect to 32'h0000_0100 while req to 0x8 is pending.
  - The 0x8 data is discarded.
  - Next request goes to 0x100, and the first valid `instr_pc`=0x100.
- Redirect and ack in the same cycle:
  - Data discarded.
  - `imem_addr`=`redirect_pc` on the next cycle.
  - The queue is empty that cycle.
- Wrap and async reset:
  - Redirect to 32'hFFFF_FFFC gives the next fetch at 0x0.
  - Asserting `reset` mid-request clears `imem_req` and `instr_valid` without a clock edge.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

    // Fetch FSM: IDLE has nothing outstanding, REQ has a live request,
    // DROP has a request outstanding whose data will be thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } ifetch_state_t;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifq_fifo.sv
// Circular prefetch queue holding {pc, instr} entries. Pointers wrap modulo
// DEPTH. When the queue is empty, the head output keeps the last head value.
module ifq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           head_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] last_q;

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : last_q;

    // Storage, pointers and occupancy; flush empties the queue and wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (valid_o) begin
                last_q <= mem_q[rd_ptr_q];
            end
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_i) begin
                    mem_q[wr_ptr_q] <= data_i;
                    wr_ptr_q        <= wr_ptr_q + PW'(1);
                end
                if (pop_i) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_q + CW'(push_i) - CW'(pop_i);
            end
        end
    end

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, issues one request at a
// time to instruction memory and queues returned words with their PCs.
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int unsigned CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    ifetch_state_t state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   drop_addr_q, drop_addr_d;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic [63:0]   fifo_head;
    logic          fifo_valid;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc_al;
    logic          unused_redirect_lsbs;

    assign redirect_pc_al       = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A redirect discards any same-cycle push and turns a pop into a no-op.
    assign push       = (state_q == REQ) && imem_ack && !redirect;
    assign pop        = fifo_valid && instr_ready && !redirect;
    assign count_next = redirect ? '0 : (fifo_count + CW'(push) - CW'(pop));

    assign imem_req    = (state_q != IDLE);
    // DROP must keep presenting the abandoned address while fpc already holds the redirect target.
    assign imem_addr   = (state_q == DROP) ? drop_addr_q : fpc_q;
    assign instr_valid = fifo_valid;
    assign instr_pc    = fifo_head[63:32];
    assign instr       = fifo_head[31:0];

    // Fetch FSM state, fetch PC and held address of a dropped request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            fpc_q       <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // Next-state and fetch-PC update.
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        drop_addr_d = drop_addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fpc_d   = redirect_pc_al;
                    state_d = REQ;
                end else if (count_next < FULL) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fpc_d = redirect_pc_al;
                    if (!imem_ack) begin
                        state_d     = DROP;
                        drop_addr_d = fpc_q;
                    end
                end else if (imem_ack) begin
                    fpc_d = fpc_q + 32'(WORD_BYTES);
                    if (count_next >= FULL) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fpc_d = redirect_pc_al;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ifq_fifo #(
        .WIDTH(64),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (reset),
        .push_i (push),
        .data_i ({fpc_q, imem_rdata}),
        .pop_i  (pop),
        .flush_i(redirect),
        .count_o(fifo_count),
        .valid_o(fifo_valid),
        .head_o (fifo_head)
    );

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer with a zero-latency-capable memory model.
module tb_ifetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
    endfunction

    assign imem_rdata = imem_ack ? memf(imem_addr) : 32'h0;

    ifetch_buffer #(
        .DEPTH(4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reset asserted and released between two clock edges; idle inputs.
    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #2;
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc",    instr_pc, 32'h0);

        // Stream: ack and ready always high.
        do_reset();
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("str_req0",   32'(imem_req), 32'd1);
        chk("str_addr0",  imem_addr, 32'h0);
        chk("str_valid0", 32'(instr_valid), 32'd0);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            chk("str_addr",  imem_addr, 32'(4 * k));
            chk("str_valid", 32'(instr_valid), 32'd1);
            chk("str_pc",    instr_pc, 32'(4 * (k - 1)));
            chk("str_instr", instr, memf(32'(4 * (k - 1))));
        end

        // Full queue: four pushes, stall, one pop, one more fetch at 16.
        do_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_req",  32'(imem_req), 32'd1);
            chk("full_addr", imem_addr, 32'(4 * k));
        end
        @(negedge clk);
        chk("full_req_off", 32'(imem_req), 32'd0);
        chk("full_head_pc", instr_pc, 32'h0);
        chk("full_valid",   32'(instr_valid), 32'd1);
        @(negedge clk);
        chk("full_still_off", 32'(imem_req), 32'd0);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("full_refill_req",  32'(imem_req), 32'd1);
        chk("full_refill_addr", imem_addr, 32'd16);
        chk("full_head_pc1",    instr_pc, 32'd4);
        @(negedge clk);
        chk("full_req_off2", 32'(imem_req), 32'd0);

        // Slow memory: each request acked on its third cycle.
        do_reset();
        instr_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (c == 0) imem_ack = 1'b0;
                chk("slow_req",  32'(imem_req), 32'd1);
                chk("slow_addr", imem_addr, 32'(4 * j));
                if (j > 0 && c == 0) begin
                    chk("slow_valid", 32'(instr_valid), 32'd1);
                    chk("slow_pc",    instr_pc, 32'(4 * (j - 1)));
                    chk("slow_instr", instr, memf(32'(4 * (j - 1))));
                end
            end
            imem_ack = 1'b1;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        chk("slow_last_pc",    instr_pc, 32'd8);
        chk("slow_last_instr", instr, memf(32'd8));
        @(negedge clk);
        chk("slow_drained", 32'(instr_valid), 32'd0);

        // Redirect while the request to 0x8 is outstanding.
        do_reset();
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rdo_addr8", imem_addr, 32'h8);
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        redirect = 1'b0;
        chk("rdo_req_held",  32'(imem_req), 32'd1);
        chk("rdo_addr_held", imem_addr, 32'h8);
        chk("rdo_flushed",   32'(instr_valid), 32'd0);
        imem_ack = 1'b1;
        @(negedge clk);
        chk("rdo_new_addr", imem_addr, 32'h100);
        chk("rdo_dropped",  32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("rdo_valid", 32'(instr_valid), 32'd1);
        chk("rdo_pc",    instr_pc, 32'h100);
        chk("rdo_instr", instr, memf(32'h100));

        // Redirect and ack in the same cycle; low PC bits are ignored.
        do_reset();
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rda_pre_valid", 32'(instr_valid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        @(negedge clk);
        redirect = 1'b0;
        chk("rda_addr",  imem_addr, 32'h200);
        chk("rda_empty", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("rda_pc", instr_pc, 32'h200);

        // PC wrap, then asynchronous reset with a request pending.
        do_reset();
        instr_ready = 1'b1;
        @(negedge clk);
        imem_ack    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("wrap_addr_zero", imem_addr, 32'h0);
        chk("wrap_pc",        instr_pc, 32'hFFFF_FFFC);
        chk("wrap_valid",     32'(instr_valid), 32'd1);
        instr_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_req",   32'(imem_req), 32'd0);
        chk("async_valid", 32'(instr_valid), 32'd0);
        #2;
        reset = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
